aes_v3_round_seq: RTL and testbench

//  Multi-cycle initiator that drives one instance of the v3 byte-step unit
//  (aes_v3_1: rd = rs1 ^ rot(mix?(sbox(rs2.byte[bs])), bs)) to compute one full
//  AES round on a 128-bit state. One byte-step per cycle, 16 steps per round.

---
 rtl/aes_v3_pkg.sv | 48 ++++
 rtl/aes_v3_1.sv | 32 +++
 rtl/aes_v3_round_seq.sv | 90 +++++++++
 tb/tb_aes_v3_round_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/aes_v3_pkg.sv
// aes_v3_pkg: round-sequencer FSM encoding, ShiftRows column selects and GF(2^8) S-box helpers.
package aes_v3_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } st_e;
  function automatic logic [1:0] col_enc(input logic [1:0] col, input logic [1:0] bs);
    return col + bs;
  endfunction
  function automatic logic [1:0] col_dec(input logic [1:0] col, input logic [1:0] bs);
    return col - bs;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ t : p;
      t = xtime(t);
    end
    return p;
  endfunction
  // x^254 is the field inverse for x != 0 and maps 0 to 0, as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction
endpackage

// File: rtl/aes_v3_1.sv
// aes_v3_1: single-cycle AES byte step, rd = rs1 ^ rot(mix?(sbox(rs2.byte[bs])), bs).
module aes_v3_1 import aes_v3_pkg::*; #(
  parameter int DECRYPT_EN = 1
) (
  input  logic        i_valid,
  input  logic        i_dec,
  input  logic        i_mix,
  input  logic [1:0]  i_bs,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_rd
);
  logic        w_dec;
  logic [7:0]  w_x;
  logic [7:0]  w_sb;
  logic [31:0] w_mix;
  logic [31:0] w_rot;
  // The mixed word holds the MixColumns column for row 0; rotating by bs places row bs.
  always_comb begin
    w_dec = i_dec & (DECRYPT_EN != 0);
    w_x   = i_rs2[{i_bs, 3'b000} +: 8];
    w_sb  = w_dec ? sbox_inv(w_x) : sbox_fwd(w_x);
    w_mix = !i_mix ? {24'h0, w_sb} :
            w_dec  ? {gf_mul(w_sb, 8'h0b), gf_mul(w_sb, 8'h0d), gf_mul(w_sb, 8'h09), gf_mul(w_sb, 8'h0e)} :
                     {gf_mul(w_sb, 8'h03), w_sb, w_sb, xtime(w_sb)};
    w_rot = (i_bs == 2'd0) ? w_mix :
            (i_bs == 2'd1) ? {w_mix[23:0], w_mix[31:24]} :
            (i_bs == 2'd2) ? {w_mix[15:0], w_mix[31:16]} :
                             {w_mix[7:0], w_mix[31:8]};
    o_rd  = i_valid ? i_rs1 ^ w_rot : 32'h0;
  end
endmodule

// File: rtl/aes_v3_round_seq.sv
// aes_v3_round_seq: sequences 16 aes_v3_1 byte steps into one full AES round.
module aes_v3_round_seq import aes_v3_pkg::*; #(
  parameter int DECRYPT_EN = 1
) (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dec,
  input  logic         in_last,
  input  logic [127:0] in_state,
  input  logic [127:0] in_rkey,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  st_e          r_state;
  st_e          w_next;
  logic [3:0]   r_cnt;
  logic         r_dec;
  logic         r_last;
  logic [127:0] r_in;
  logic [127:0] r_rkey;
  logic [127:0] r_out;
  logic [31:0]  r_acc;
  logic [31:0]  w_rs1;
  logic [31:0]  w_rs2;
  logic [31:0]  w_rd;
  logic [1:0]   w_col;
  logic [1:0]   w_bs;
  logic [1:0]   w_src;
  logic         w_run;
  logic         w_accept;
  assign in_ready  = r_state == ST_IDLE;
  assign out_valid = r_state == ST_DONE;
  assign out_state = r_out;
  assign w_run     = r_state == ST_RUN;
  assign w_accept  = in_valid & in_ready;
  assign w_col     = r_cnt[3:2];
  assign w_bs      = r_cnt[1:0];
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == ST_IDLE && in_valid)        ? ST_RUN  :
             (r_state == ST_RUN  && r_cnt == 4'hf)   ? ST_DONE :
             (r_state == ST_DONE && out_ready)       ? ST_IDLE : r_state;
  end
  // Operands are forced to zero outside RUN so the step unit sees no stale columns.
  always_comb begin
    w_src = r_dec ? col_dec(w_col, w_bs) : col_enc(w_col, w_bs);
    w_rs2 = w_run ? r_in[{w_src, 5'b00000} +: 32] : 32'h0;
    w_rs1 = !w_run ? 32'h0 : (w_bs == 2'd0) ? r_rkey[{w_col, 5'b00000} +: 32] : r_acc;
  end
  aes_v3_1 #(.DECRYPT_EN(DECRYPT_EN)) i_aes_v3_1 (
    .i_valid (w_run),
    .i_dec   (r_dec),
    .i_mix   (~r_last),
    .i_bs    (w_bs),
    .i_rs1   (w_rs1),
    .i_rs2   (w_rs2),
    .o_rd    (w_rd)
  );
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_cnt  <= 4'h0;
      r_dec  <= 1'b0;
      r_last <= 1'b0;
      r_in   <= 128'h0;
      r_rkey <= 128'h0;
      r_out  <= 128'h0;
      r_acc  <= 32'h0;
    end else begin
      if (w_accept) begin
        r_cnt  <= 4'h0;
        r_dec  <= in_dec & (DECRYPT_EN != 0);
        r_last <= in_last;
        r_in   <= in_state;
        r_rkey <= in_rkey;
      end
      if (w_run) begin
        r_cnt <= r_cnt + 4'h1;
        r_acc <= w_rd;
        if (w_bs == 2'd3) r_out[{w_col, 5'b00000} +: 32] <= w_rd;
      end
    end
  end
endmodule

// File: tb/tb_aes_v3_round_seq.sv
// tb_aes_v3_round_seq: directed vectors and handshake/reset sequences for the AES round sequencer.
module tb_aes_v3_round_seq;
  typedef struct {
    logic         dec;
    logic         last;
    logic [127:0] st;
    logic [127:0] rk;
    logic [127:0] exp;
    logic         ck_main;
    logic [127:0] exp_nd;
    logic         ck_nd;
  } vec_t;
  logic         clk = 1'b0;
  logic         g_reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_dec = 1'b0;
  logic         in_last = 1'b0;
  logic [127:0] in_state = 128'h0;
  logic [127:0] in_rkey = 128'h0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_state;
  logic         nd_in_ready;
  logic         nd_out_valid;
  logic [127:0] nd_out_state;
  int           n_cmp = 0;
  int           n_fail = 0;
  vec_t         tbl[6];
  always #5 clk = ~clk;
  aes_v3_round_seq #(.DECRYPT_EN(1)) u_dut (
    .g_clk(clk), .g_reset(g_reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_dec(in_dec), .in_last(in_last), .in_state(in_state), .in_rkey(in_rkey),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
  );
  aes_v3_round_seq #(.DECRYPT_EN(0)) u_nd (
    .g_clk(clk), .g_reset(g_reset), .in_valid(in_valid), .in_ready(nd_in_ready),
    .in_dec(in_dec), .in_last(in_last), .in_state(in_state), .in_rkey(in_rkey),
    .out_valid(nd_out_valid), .out_ready(out_ready), .out_state(nd_out_state)
  );
  function automatic logic [127:0] bsw(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
    return r;
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    in_dec   = v.dec;
    in_last  = v.last;
    in_state = v.st;
    in_rkey  = v.rk;
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic run_req(input int idx, input vec_t v);
    int cyc;
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cyc);
    check($sformatf("v%0d latency", idx), cyc, 16);
    if (v.ck_main) check($sformatf("v%0d out_state", idx), out_state, v.exp);
    if (v.ck_nd) check($sformatf("v%0d nd out_state", idx), nd_out_state, v.exp_nd);
    check($sformatf("v%0d in_ready busy", idx), in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("v%0d in_ready after", idx), in_ready, 1);
    check($sformatf("v%0d out_valid after", idx), out_valid, 0);
    if (v.ck_main) check($sformatf("v%0d out_state hold", idx), out_state, v.exp);
  endtask
  initial begin
    int cyc;
    tbl[0] = '{1'b0, 1'b0, bsw(128'h193de3bea0f4e22b9ac68d2ae9f84808), bsw(128'ha0fafe1788542cb123a339392a6c7605),
               bsw(128'ha49c7ff2689f352b6b5bea43026a5049), 1'b1, bsw(128'ha49c7ff2689f352b6b5bea43026a5049), 1'b1};
    tbl[1] = '{1'b0, 1'b1, bsw(128'heb40f21e592e38848ba113e71bc342d2), bsw(128'hd014f9a8c9ee2589e13f0cc8b6630ca6),
               bsw(128'h3925841d02dc09fbdc118597196a0b32), 1'b1, bsw(128'h3925841d02dc09fbdc118597196a0b32), 1'b1};
    tbl[2] = '{1'b1, 1'b1, bsw(128'he9317db5cb322c723d2e895faf090794), 128'h0,
               bsw(128'heb40f21e592e38848ba113e71bc342d2), 1'b1, 128'h0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, bsw(128'heb40f21e592e38848ba113e71bc342d2), bsw(128'hd014f9a8c9ee2589e13f0cc8b6630ca6),
               128'h0, 1'b0, bsw(128'h3925841d02dc09fbdc118597196a0b32), 1'b1};
    tbl[4] = '{1'b0, 1'b0, 128'h0, {16{8'hff}}, {16{8'h9c}}, 1'b1, {16{8'h9c}}, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 128'h0, 128'h0, {16{8'h52}}, 1'b1, {16{8'h63}}, 1'b1};
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_state", out_state, 0);
    g_reset = 1'b0;
    for (int i = 0; i < 6; i++) run_req(i, tbl[i]);
    // Handshake: hold the result with a competing request present throughout.
    @(negedge clk);
    drive(tbl[0]);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    drive(tbl[1]);
    wait_valid(cyc);
    check("hs latency", cyc, 16);
    check("hs out_state", out_state, tbl[0].exp);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hs hold%0d out_valid", k), out_valid, 1);
      check($sformatf("hs hold%0d out_state", k), out_state, tbl[0].exp);
      check($sformatf("hs hold%0d in_ready", k), in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hs in_ready after", in_ready, 1);
    check("hs out_valid after", out_valid, 0);
    // Back-to-back rounds with both sides always ready.
    drive(tbl[0]);
    in_valid = 1'b1;
    @(negedge clk);
    wait_valid(cyc);
    check("tp first valid", out_valid, 1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 40);
    in_valid = 1'b0;
    check("tp period", cyc, 18);
    check("tp out_state", out_state, tbl[0].exp);
    @(negedge clk);
    out_ready = 1'b0;
    // Asynchronous abort partway through a round.
    drive(tbl[1]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("abort pre out_state", out_state != 128'h0, 1);
    g_reset = 1'b1;
    #1;
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort out_state", out_state, 0);
    @(negedge clk);
    g_reset = 1'b0;
    run_req(6, tbl[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
